dm_arbiter: RTL and testbench

//  Shares the single-port 4K-byte data memory between the pipeline MEM stage (port 0)
//  and a debug/DMA master (port 1). Round-robin arbitration, one word access per grant,

---
 rtl/dm_arbiter.sv | 135 +++++++++++++
 tb/tb_dm_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the MEM stage (port 0)
// and a debug/DMA master (port 1); one word access per grant, ack one cycle after ACCESS.
module dm_arbiter #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [31:0]   p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_ack,
  output logic          p0_err,
  output logic [DW-1:0] p0_rdata,
  output logic          p0_stall,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [31:0]   p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_ack,
  output logic          p1_err,
  output logic [DW-1:0] p1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  output logic          mem_we,
  input  logic [DW-1:0] mem_dout,
  output logic [1:0]    dbg_state
);

  // Handshake: a port raises req with we/addr/wdata stable and holds them until its
  // one-cycle ack; req is only sampled in IDLE, so req high there is always a new request.

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_last_grant;
  logic          r_cur_port;
  logic          r_we;
  logic [AW+1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rdata_q;
  logic          r_err_q;

  logic          w_any_req;
  logic          w_win;
  logic          w_aligned;
  logic          w_unused;

  assign w_any_req = p0_req | p1_req;
  // On a tie the port that did not win last time gets the grant.
  assign w_win     = (p0_req & p1_req) ? ~r_last_grant : p1_req;
  assign w_aligned = (r_addr[1:0] == 2'b00);
  // Byte-address bits above the memory size are deliberately ignored (address wraps).
  assign w_unused  = ^{p0_addr[31:AW+2], p1_addr[31:AW+2]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_any_req) w_next = S_ACCESS;
      S_ACCESS: w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= 1'b1;
      r_cur_port   <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata_q    <= '0;
      r_err_q      <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_any_req) begin
        r_cur_port   <= w_win;
        r_last_grant <= w_win;
        r_we         <= w_win ? p1_we : p0_we;
        r_addr       <= w_win ? p1_addr[AW+1:0] : p0_addr[AW+1:0];
        r_wdata      <= w_win ? p1_wdata : p0_wdata;
      end
      if (r_state == S_ACCESS) begin
        r_rdata_q <= (w_aligned && !r_we) ? mem_dout : '0;
        r_err_q   <= ~w_aligned;
      end
    end
  end

  always_comb begin
    mem_addr = '0;
    mem_din  = '0;
    mem_we   = 1'b0;
    p0_ack   = 1'b0;
    p0_err   = 1'b0;
    p0_rdata = '0;
    p1_ack   = 1'b0;
    p1_err   = 1'b0;
    p1_rdata = '0;
    case (r_state)
      S_ACCESS: begin
        mem_addr = r_addr[AW+1:2];
        mem_din  = r_wdata;
        mem_we   = r_we & w_aligned;
      end
      S_RESP: begin
        if (r_cur_port) begin
          p1_ack   = 1'b1;
          p1_err   = r_err_q;
          p1_rdata = r_rdata_q;
        end else begin
          p0_ack   = 1'b1;
          p0_err   = r_err_q;
          p0_rdata = r_rdata_q;
        end
      end
      default: ;
    endcase
  end

  assign p0_stall  = p0_req & ~p0_ack;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed plus short random bench for dm_arbiter with a behavioural data memory
// and per-port expected-response queues.
module tb_dm_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk, rst;
  logic          p0_req, p0_we, p0_ack, p0_err, p0_stall;
  logic [31:0]   p0_addr;
  logic [DW-1:0] p0_wdata, p0_rdata;
  logic          p1_req, p1_we, p1_ack, p1_err;
  logic [31:0]   p1_addr;
  logic [DW-1:0] p1_wdata, p1_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, mem_dout;
  logic          mem_we;
  logic [1:0]    dbg_state;

  logic [DW-1:0] mem     [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic [DW:0]   exp0_q[$];
  logic [DW:0]   exp1_q[$];
  int            n_cmp = 0;
  int            n_bad = 0;

  dm_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata), .p0_stall(p0_stall),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout),
    .dbg_state(dbg_state)
  );

  // clock / memory
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_din;
  assign mem_dout = mem[mem_addr];

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // driver tasks
  task automatic drive(input int p, input logic we, input logic [31:0] a, input logic [31:0] d);
    logic          err;
    logic [DW-1:0] rd;
    @(negedge clk);
    if (p == 0) begin p0_req = 1'b1; p0_we = we; p0_addr = a; p0_wdata = d; end
    else        begin p1_req = 1'b1; p1_we = we; p1_addr = a; p1_wdata = d; end
    err = (a[1:0] != 2'b00);
    rd  = (!err && !we) ? ref_mem[a[AW+1:2]] : '0;
    if (!err && we) ref_mem[a[AW+1:2]] = d;
    if (p == 0) exp0_q.push_back({err, rd});
    else        exp1_q.push_back({err, rd});
  endtask

  task automatic drop(input int p);
    if (p == 0) p0_req = 1'b0;
    else        p1_req = 1'b0;
  endtask

  // scoreboard: wait for ack on port p (bounded), then pop and compare the response
  task automatic wait_ack(input int p, input int exp_lat, input string tag);
    int          cyc = 0;
    bit          got = 0;
    logic [DW:0] e, o;
    while (!got && cyc < 10) begin
      @(negedge clk);
      cyc++;
      got = (p == 0) ? p0_ack : p1_ack;
    end
    chk({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
    o = (p == 0) ? {p0_err, p0_rdata} : {p1_err, p1_rdata};
    if (p == 0) e = (exp0_q.size() > 0) ? exp0_q.pop_front() : '1;
    else        e = (exp1_q.size() > 0) ? exp1_q.pop_front() : '1;
    chk({tag, "_resp"}, 64'(o), 64'(e));
    chk({tag, "_other_ack"}, 64'((p == 0) ? p1_ack : p0_ack), 64'd0);
  endtask

  initial begin
    bit seen;
    for (int i = 0; i < (1 << AW); i++) begin mem[i] = '0; ref_mem[i] = '0; end
    rst = 1'b1;
    p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
    p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
    #1;
    chk("rst_state", 64'(dbg_state), 64'd0);
    chk("rst_acks", 64'({p0_ack, p1_ack, mem_we}), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // tie after reset: p0 first, p1 next, then p0 wins the next tie
    drive(0, 1'b1, 32'h40, 32'hAAAA_0001);
    drive(1, 1'b1, 32'h44, 32'hBBBB_0002);
    // drive() for p1 consumed one extra negedge; p1 raised in the ACCESS cycle of p0
    wait_ack(0, 1, "tie1_p0");
    drop(0);
    wait_ack(1, 3, "tie1_p1");
    drop(1);
    @(negedge clk);
    p0_req = 1; p0_we = 0; p0_addr = 32'h40;
    p1_req = 1; p1_we = 0; p1_addr = 32'h44;
    exp0_q.push_back({1'b0, ref_mem[16]});
    exp1_q.push_back({1'b0, ref_mem[17]});
    wait_ack(0, 2, "tie2_p0");
    drop(0);
    wait_ack(1, 3, "tie2_p1");
    drop(1);

    // p0 aligned write, memory side visible in ACCESS
    drive(0, 1'b1, 32'h10, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("t1_mem_we", 64'(mem_we), 64'd1);
    chk("t1_mem_addr", 64'(mem_addr), 64'd4);
    chk("t1_mem_din", 64'(mem_din), 64'hDEAD_BEEF);
    wait_ack(0, 1, "t1");
    drop(0);

    drive(0, 1'b0, 32'h10, 32'h0);
    wait_ack(0, 2, "t2_read");
    drop(0);

    // misaligned write from p1
    drive(1, 1'b1, 32'h12, 32'h5555_5555);
    @(negedge clk);
    chk("t4_mem_we", 64'(mem_we), 64'd0);
    wait_ack(1, 1, "t4");
    drop(1);
    chk("t4_word4", 64'(mem[4]), 64'hDEAD_BEEF);

    // stall window and address wrap
    drive(0, 1'b1, 32'h1004, 32'hC0DE_0004);
    #1 chk("t6_stall_req", 64'(p0_stall), 64'd1);
    @(negedge clk);
    chk("t6_stall_access", 64'(p0_stall), 64'd1);
    chk("t6_wrap_addr", 64'(mem_addr), 64'd1);
    wait_ack(0, 1, "t6");
    chk("t6_stall_ack", 64'(p0_stall), 64'd0);
    drop(0);
    chk("t6_word1", 64'(mem[1]), 64'hC0DE_0004);
    drive(0, 1'b0, 32'h4, 32'h0);
    wait_ack(0, 2, "t6_readback");
    drop(0);

    // short random traffic
    for (int i = 0; i < 8; i++) begin
      int            p;
      logic          we;
      logic [31:0]   a;
      p  = $urandom_range(0, 1);
      we = 1'($urandom_range(0, 1));
      a  = (32'($urandom_range(0, 1023)) << 2) | ((i == 5) ? 32'd3 : 32'd0);
      drive(p, we, a, $urandom);
      wait_ack(p, 2, "rnd");
      drop(p);
    end

    // reset during ACCESS drops the write and the ack
    drive(0, 1'b1, 32'h20, 32'h0000_1234);
    void'(exp0_q.pop_back());
    ref_mem[8] = mem[8];
    @(negedge clk);
    chk("t5_we_before", 64'(mem_we), 64'd1);
    rst = 1'b1;
    #1;
    chk("t5_we_drop", 64'(mem_we), 64'd0);
    chk("t5_state", 64'(dbg_state), 64'd0);
    drop(0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (p0_ack || p1_ack) seen = 1;
    end
    chk("t5_no_ack", 64'(seen), 64'd0);
    chk("t5_word8", 64'(mem[8]), 64'(ref_mem[8]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
